fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the five-stage pipeline. It owns the program counter, issues instruction-memory reads, and applies static branch prediction: backward conditional branches and direct jumps are predicted taken. It also holds the fetch/decode pipeline latch, drives the fetch side of `fetch_decode_if`, and accepts corrected targets back from decode.

## Interface
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction memory returned `imemload` for `iaddr` this cycle.
- `imemload`  in  32  instruction word from memory.
- `iREN`  out  1  instruction read enable.
- `iaddr`  out  32  instruction address; always equals the current PC.
- `fd_stall`  in  1  from the hazard unit: hold the PC and the F/D latch.
- `fd_flush`  in  1  from later stages: replace the F/D latch contents with a bubble.
- `redirect`  in  1  decode reports a mispredict or taken correction; the PC loads `fdif.branch_target`.
- `fdif`  modport  `fetch_decode_if.fetch`:
  - outputs: `instruction`, `instr_npc`, `branch_taken`
  - input: `branch_target`

## Operation
- **State**
  - `pc` (word_t)
  - `halted` (1 bit)
  - F/D latch: `instruction`, `instr_npc`, `branch_taken`
- **Combinational outputs**
  - `iaddr = pc`
  - `iREN = !halted`
- **Predictor (combinational on `imemload`, `pc`)**
  - `npc = pc + 4`.
  - BEQ (6'h04) or BNE (6'h05) with `imm[15]=1`: predict taken; target = `npc + (sext(imm16) << 2)`.
  - BEQ or BNE with `imm[15]=0`: predict not taken; next = `npc`.
  - J (6'h02) or JAL (6'h03): taken; target = `{npc[31:28], instr[25:0], 2'b00}`.
  - JR and all other opcodes: not taken; next = `npc`.
- **Per-cycle update, highest priority first**
  1. **`redirect`**
     - `pc <= fdif.branch_target`
     - latch <= bubble (`instruction=0`, `instr_npc=0`, `branch_taken=0`)
     - `halted <= 0`
     - Applies even when `fd_stall` or `halted` is set.
  2. **`fd_stall`**: PC, latch and `halted` all hold, regardless of `ihit`.
  3. **`halted`**: PC holds; latch <= bubble.
  4. **`ihit`**
     - `pc <= predicted next`
     - latch <= {`imemload`, `npc`, taken bit}
     - If opcode is HALT (6'h3F): `pc` holds, `halted <= 1`, and HALT itself is latched.
  5. **`!ihit`**: PC holds; latch <= bubble.
- **`fd_flush`**
  - Forces the latch to a bubble in any case not covered by rules 1–2.
  - Under rule 2 (stall) it still forces the bubble; flush overrides stall for the latch only, and the PC still holds.
- A bubble is all-zero, which is `sll $0,$0,0`, a NOP.

## Timing
- **Reset (async, `nRST=0`)**
  - `pc=PC_INIT`, `halted=0`
  - `instruction=0`, `instr_npc=0`, `branch_taken=0`
  - Therefore `iaddr=PC_INIT` and `iREN=1`.
- **Latency**
  - An instruction read in cycle N (with `ihit`) appears on `fdif` from edge N+1.
  - A taken prediction redirects `iaddr` at edge N+1, so there is zero bubble for a correct prediction.
- **Redirect penalty**: one bubble. The wrong-path instruction fetched in the redirect cycle is discarded, and `iaddr=branch_target` from the next edge.
- **PC width**: PC arithmetic is 32-bit modulo, so 32'hFFFF_FFFC + 4 wraps to 0 with no special handling.
- **Mid-operation reset**: reset during a stall or halt immediately restores the reset values; no pending state survives.
- **No back-to-back HALT**: HALT is latched exactly once, then bubbles follow until a redirect or reset.

## Structure
- `cpu_types_pkg`: `word_t`, `opcode_t` enumeration (BEQ, BNE, J, JAL, HALT, RTYPE), instruction field typedefs (`i_t`, `j_t`). No new package.
- Sub-module `fetch_predict`: purely combinational, (instr, npc) -> (taken, target). It is instantiated once inside `fetch_stage` and tested in isolation.
- The F/D latch lives in `fetch_stage`, not as a separate module.

## Test plan
- **Reset, then straight-line code**
  - Stimulus: `nRST` low, then high; `ihit=1` with ADDU words.
  - Response: `iaddr` sequence 0, 4, 8; `instr_npc` sequence 4, 8, 12; `branch_taken=0`.
- **Backward BEQ at pc=0x10, imm=16'hFFFC**
  - Response: next `iaddr=0x04`; latch `branch_taken=1`, `instr_npc=0x14`.
- **Forward BNE at 0x20, imm=3; J at 0x24 to 26'h40**
  - Response: BNE not taken, so `iaddr=0x24`; then J is taken, so `iaddr=0x100` with `branch_taken=1`.
- **`redirect` with `branch_target=0x200` asserted while `fd_stall=1`**
  - Response: next edge `iaddr=0x200`, latch=0, redirect wins.
- **`ihit` low for 3 cycles at 0x40**
  - Response: `iaddr` stays 0x40; three bubbles; with `fd_stall` also high, the latch holds its prior value instead.
- **HALT fetched at 0x50**
  - Response: HALT latched once; `iREN=0` and bubbles thereafter.
  - A later `redirect` to 0x60 gives `iREN=1` and `iaddr=0x60`.
  - Async `nRST` pulse mid-halt restores `iaddr=PC_INIT`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, opcode and instruction-field types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        HALT  = 6'h3F
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [25:0] addr;
    } j_t;

    typedef struct packed {
        word_t instruction;
        word_t instr_npc;
        logic  branch_taken;
    } fd_latch_t;

endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: fetch/decode pipeline latch outputs and the corrected-target return path.
interface fetch_decode_if
    import cpu_types_pkg::*;
();
    word_t instruction;
    word_t instr_npc;
    logic  branch_taken;
    word_t branch_target;

    modport fetch  (output instruction, instr_npc, branch_taken, input branch_target);
    modport decode (input instruction, instr_npc, branch_taken, output branch_target);
endinterface

// File: rtl/fetch_predict.sv
// fetch_predict: static predictor; backward BEQ/BNE and J/JAL taken, all else falls through.
module fetch_predict
    import cpu_types_pkg::*;
(
    input  word_t instr_i,
    input  word_t npc_i,
    output logic  taken_o,
    output word_t target_o
);
    j_t          jf;
    logic [15:0] imm;
    logic        is_br;
    logic        is_j;
    assign jf       = j_t'(instr_i);
    assign imm      = instr_i[15:0];
    assign is_br    = (jf.opcode == BEQ) || (jf.opcode == BNE);
    assign is_j     = (jf.opcode == J) || (jf.opcode == JAL);
    assign taken_o  = is_j || (is_br && imm[15]);
    assign target_o = is_j    ? {npc_i[31:28], jf.addr, 2'b00} :
                      taken_o ? npc_i + {{14{imm[15]}}, imm, 2'b00} : npc_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory read, static prediction and the F/D latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  fd_stall,
    input  logic  fd_flush,
    input  logic  redirect,
    fetch_decode_if.fetch fdif
);
    word_t     pc_q, pc_d, npc, pred_target;
    logic      halted_q, halted_d, pred_taken, is_halt;
    fd_latch_t latch_q, latch_d;

    assign npc     = pc_q + 32'd4;
    assign is_halt = opcode_t'(imemload[31:26]) == HALT;
    assign iaddr   = pc_q;
    assign iREN    = !halted_q;
    assign fdif.instruction  = latch_q.instruction;
    assign fdif.instr_npc    = latch_q.instr_npc;
    assign fdif.branch_taken = latch_q.branch_taken;

    fetch_predict u_predict (
        .instr_i  (imemload),
        .npc_i    (npc),
        .taken_o  (pred_taken),
        .target_o (pred_target)
    );

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        latch_d  = latch_q;
        if (redirect) begin
            pc_d     = fdif.branch_target;
            halted_d = 1'b0;
            latch_d  = '0;
        end else if (fd_stall) begin
            latch_d = fd_flush ? '0 : latch_q;
        end else begin
            latch_d = '0;
            if (!halted_q && ihit) begin
                // HALT parks the PC on itself and is latched exactly once
                pc_d     = is_halt ? pc_q : (pred_taken ? pred_target : npc);
                halted_d = is_halt;
                latch_d  = fd_flush ? '0 : '{imemload, npc, pred_taken};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q     <= PC_INIT;
            halted_q <= 1'b0;
            latch_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            latch_q  <= latch_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t ADDU = 32'h0022_1821;
    localparam word_t BEQB = 32'h1022_FFFC;
    localparam word_t BNEF = 32'h1422_0003;
    localparam word_t JMP  = 32'h0800_0040;
    localparam word_t HLT  = 32'hFC00_0000;

    logic  CLK = 1'b0, nRST = 1'b0, ihit = 1'b0, iREN;
    logic  fd_stall = 1'b0, fd_flush = 1'b0, redirect = 1'b0;
    word_t imemload = '0, iaddr;
    int    n_run = 0, n_fail = 0;

    fetch_decode_if fdif ();

    fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .fd_stall (fd_stall),
        .fd_flush (fd_flush),
        .redirect (redirect),
        .fdif     (fdif)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic latch(input string tag, input word_t ins, input word_t npc, input logic tk);
        check({tag, ".instr"}, fdif.instruction, ins);
        check({tag, ".npc"}, fdif.instr_npc, npc);
        check({tag, ".taken"}, {31'd0, fdif.branch_taken}, {31'd0, tk});
    endtask

    task automatic do_redirect(input word_t tgt);
        redirect = 1'b1;
        fdif.branch_target = tgt;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        fdif.branch_target = '0;
        #3;
        check("rst.iaddr", iaddr, 32'h0);
        check("rst.iren", {31'd0, iREN}, 32'd1);
        latch("rst", 32'h0, 32'h0, 1'b0);
        nRST = 1'b1;
        ihit = 1'b1;
        imemload = ADDU;
        step(); check("seq.iaddr4", iaddr, 32'h4);  latch("seq1", ADDU, 32'h4, 1'b0);
        step(); check("seq.iaddr8", iaddr, 32'h8);  latch("seq2", ADDU, 32'h8, 1'b0);
        step(); check("seq.iaddrC", iaddr, 32'hC);  latch("seq3", ADDU, 32'hC, 1'b0);
        step(); check("seq.iaddr10", iaddr, 32'h10);
        imemload = BEQB;
        step(); check("beq.iaddr", iaddr, 32'h4); latch("beq", BEQB, 32'h14, 1'b1);
        imemload = ADDU;
        do_redirect(32'h20);
        check("redir20.iaddr", iaddr, 32'h20); latch("redir20", 32'h0, 32'h0, 1'b0);
        imemload = BNEF;
        step(); check("bne.iaddr", iaddr, 32'h24); latch("bne", BNEF, 32'h24, 1'b0);
        imemload = JMP;
        step(); check("j.iaddr", iaddr, 32'h100); latch("j", JMP, 32'h28, 1'b1);
        fd_stall = 1'b1;
        do_redirect(32'h200);
        check("redstall.iaddr", iaddr, 32'h200); latch("redstall", 32'h0, 32'h0, 1'b0);
        fd_stall = 1'b0;
        ihit = 1'b0;
        do_redirect(32'h3C);
        check("r3c.iaddr", iaddr, 32'h3C);
        ihit = 1'b1;
        imemload = ADDU;
        step(); check("pre40.iaddr", iaddr, 32'h40); latch("pre40", ADDU, 32'h40, 1'b0);
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check("miss.iaddr", iaddr, 32'h40); latch("miss", 32'h0, 32'h0, 1'b0);
        end
        ihit = 1'b1;
        step(); check("pre44.iaddr", iaddr, 32'h44); latch("pre44", ADDU, 32'h44, 1'b0);
        fd_stall = 1'b1;
        ihit = 1'b0;
        step(); check("stmiss.iaddr", iaddr, 32'h44); latch("stmiss", ADDU, 32'h44, 1'b0);
        ihit = 1'b1;
        step(); check("sthit.iaddr", iaddr, 32'h44); latch("sthit", ADDU, 32'h44, 1'b0);
        fd_flush = 1'b1;
        step(); check("stfl.iaddr", iaddr, 32'h44); latch("stfl", 32'h0, 32'h0, 1'b0);
        fd_stall = 1'b0;
        step(); check("fl.iaddr", iaddr, 32'h48); latch("fl", 32'h0, 32'h0, 1'b0);
        fd_flush = 1'b0;
        do_redirect(32'hFFFF_FFFC);
        check("wrapr.iaddr", iaddr, 32'hFFFF_FFFC);
        step(); check("wrap.iaddr", iaddr, 32'h0); latch("wrap", ADDU, 32'h0, 1'b0);
        ihit = 1'b0;
        do_redirect(32'h50);
        ihit = 1'b1;
        imemload = HLT;
        step(); check("halt.iaddr", iaddr, 32'h50); check("halt.iren", {31'd0, iREN}, 32'd0);
        latch("halt", HLT, 32'h54, 1'b0);
        step(); check("halt2.iaddr", iaddr, 32'h50); check("halt2.iren", {31'd0, iREN}, 32'd0);
        latch("halt2", 32'h0, 32'h0, 1'b0);
        imemload = ADDU;
        do_redirect(32'h60);
        check("unhalt.iaddr", iaddr, 32'h60); check("unhalt.iren", {31'd0, iREN}, 32'd1);
        imemload = HLT;
        step(); check("halt3.iren", {31'd0, iREN}, 32'd0);
        #2 nRST = 1'b0;
        #1;
        check("arst.iaddr", iaddr, 32'h0); check("arst.iren", {31'd0, iREN}, 32'd1);
        latch("arst", 32'h0, 32'h0, 1'b0);
        ihit = 1'b0;
        #1 nRST = 1'b1;
        step(); check("post.iaddr", iaddr, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
